// File: rtl/fetch_inst_buffer.sv
// Instruction queue between fetch and decode: compacts up to two valid fetch
// slots per cycle into a circular buffer and presents the two oldest entries.
module fetch_inst_buffer #(
  parameter int DEPTH      = 8,
  parameter int META_WIDTH = 35
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [1:0]                wr_valid_i,
  input  logic [31:0]               wr_pc_i,
  input  logic [63:0]               wr_inst_i,
  input  logic [2*META_WIDTH-1:0]   wr_meta_i,
  output logic                      wr_ready_o,
  output logic [1:0]                rd_valid_o,
  output logic [63:0]               rd_pc_o,
  output logic [63:0]               rd_inst_o,
  output logic [2*META_WIDTH-1:0]   rd_meta_o,
  input  logic [1:0]                rd_pop_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]           pc_mem   [DEPTH];
  logic [31:0]           inst_mem [DEPTH];
  logic [META_WIDTH-1:0] meta_mem [DEPTH];

  logic [AW-1:0] head_q, tail_q, head_p1, tail_p1;
  logic [CW-1:0] count_q;

  logic                  push_en, push_two, pop0, pop1;
  logic                  first_is_slot1;
  logic [31:0]           w0_pc, w1_pc, w0_inst;
  logic [META_WIDTH-1:0] w0_meta;
  logic [CW-1:0]         n_push, n_pop;
  logic [AW-1:0]         head_adv, tail_adv;

  // Handshake: a write is taken on a rising edge when wr_ready_o & |wr_valid_i
  // & ~flush_i; wr_ready_o promises room for a full pair and looks only at the
  // registered count. Entry k is consumed when rd_valid_o[k] and rd_pop_i[k:0]
  // are all set; un-popped entries stay on rd_* unchanged.
  assign wr_ready_o = (count_q <= CW'(DEPTH - 2));
  assign rd_valid_o = {count_q >= CW'(2), count_q != '0};
  assign count_o    = count_q;

  assign push_en  = wr_ready_o & (|wr_valid_i) & ~flush_i;
  assign push_two = push_en & (&wr_valid_i);
  assign pop0     = rd_pop_i[0] & rd_valid_o[0];
  assign pop1     = rd_pop_i[1] & rd_pop_i[0] & rd_valid_o[1];

  // A lone slot1 instruction is compacted into the tail entry.
  assign first_is_slot1 = ~wr_valid_i[0];
  assign w1_pc   = wr_pc_i + 32'd4;
  assign w0_pc   = first_is_slot1 ? w1_pc : wr_pc_i;
  assign w0_inst = first_is_slot1 ? wr_inst_i[63:32] : wr_inst_i[31:0];
  assign w0_meta = first_is_slot1 ? wr_meta_i[2*META_WIDTH-1:META_WIDTH]
                                  : wr_meta_i[META_WIDTH-1:0];

  assign head_p1  = head_q + AW'(1);
  assign tail_p1  = tail_q + AW'(1);
  assign n_push   = CW'(push_en) + CW'(push_two);
  assign n_pop    = CW'(pop0) + CW'(pop1);
  assign head_adv = AW'(pop0) + AW'(pop1);
  assign tail_adv = AW'(push_en) + AW'(push_two);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + head_adv;
      tail_q  <= tail_q + tail_adv;
      count_q <= count_q + n_push - n_pop;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[tail_q]   <= w0_pc;
      inst_mem[tail_q] <= w0_inst;
      meta_mem[tail_q] <= w0_meta;
    end
    if (push_two) begin
      pc_mem[tail_p1]   <= w1_pc;
      inst_mem[tail_p1] <= wr_inst_i[63:32];
      meta_mem[tail_p1] <= wr_meta_i[2*META_WIDTH-1:META_WIDTH];
    end
  end

  assign rd_pc_o   = {pc_mem[head_p1], pc_mem[head_q]};
  assign rd_inst_o = {inst_mem[head_p1], inst_mem[head_q]};
  assign rd_meta_o = {meta_mem[head_p1], meta_mem[head_q]};

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Bench for fetch_inst_buffer: directed traffic, queue-based scoreboard
// checked on every falling edge, plus directed boundary checks.
module tb_fetch_inst_buffer;

  localparam int DEPTH = 8;
  localparam int MW    = 35;
  localparam int EW    = 32 + 32 + MW;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic [1:0]      wr_valid_i;
  logic [31:0]     wr_pc_i;
  logic [63:0]     wr_inst_i;
  logic [2*MW-1:0] wr_meta_i;
  logic            wr_ready_o;
  logic [1:0]      rd_valid_o;
  logic [63:0]     rd_pc_o;
  logic [63:0]     rd_inst_o;
  logic [2*MW-1:0] rd_meta_o;
  logic [1:0]      rd_pop_i;
  logic [3:0]      count_o;

  fetch_inst_buffer #(.DEPTH(DEPTH), .META_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_pc_i(wr_pc_i), .wr_inst_i(wr_inst_i),
    .wr_meta_i(wr_meta_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_inst_o(rd_inst_o),
    .rd_meta_o(rd_meta_o), .rd_pop_i(rd_pop_i), .count_o(count_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  int m_cnt;
  logic [EW-1:0] act_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wr_valid_i = 2'b00;
    wr_pc_i    = '0;
    wr_inst_i  = '0;
    wr_meta_i  = '0;
    rd_pop_i   = 2'b00;
    flush_i    = 1'b0;
  endtask

  task automatic cycle(input logic [1:0] v, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] pop, input logic fl);
    wr_valid_i = v;
    wr_pc_i    = pc;
    wr_inst_i  = {i1, i0};
    wr_meta_i  = {3'b101, i1, 3'b010, i0};
    rd_pop_i   = pop;
    flush_i    = fl;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: checks presented state, then applies this cycle's inputs
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) exp_q.delete();
      m_cnt = exp_q.size();
      check("rd_valid", 128'(rd_valid_o), 128'({m_cnt >= 2, m_cnt >= 1}));
      check("count", 128'(count_o), 128'(m_cnt));
      check("wr_ready", 128'(wr_ready_o), 128'(DEPTH - m_cnt >= 2));
      if (m_cnt >= 1) begin
        act_e = {rd_pc_o[31:0], rd_inst_o[31:0], rd_meta_o[MW-1:0]};
        check("entry0", 128'(act_e), 128'(exp_q[0]));
      end
      if (m_cnt >= 2) begin
        act_e = {rd_pc_o[63:32], rd_inst_o[63:32], rd_meta_o[2*MW-1:MW]};
        check("entry1", 128'(act_e), 128'(exp_q[1]));
      end
      if (!rst) begin
        if (flush_i) begin
          exp_q.delete();
        end else begin
          if (rd_pop_i[0] && m_cnt >= 1) void'(exp_q.pop_front());
          if (rd_pop_i == 2'b11 && m_cnt >= 2) void'(exp_q.pop_front());
          if ((DEPTH - m_cnt >= 2) && (|wr_valid_i)) begin
            if (wr_valid_i[0])
              exp_q.push_back({wr_pc_i, wr_inst_i[31:0], wr_meta_i[MW-1:0]});
            if (wr_valid_i[1])
              exp_q.push_back({wr_pc_i + 32'd4, wr_inst_i[63:32], wr_meta_i[2*MW-1:MW]});
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset mid-traffic with five entries
    cycle(2'b11, 32'h0000_1000, 32'h1111_0000, 32'h1111_0001, 2'b00, 1'b0);
    cycle(2'b11, 32'h0000_1008, 32'h1111_0002, 32'h1111_0003, 2'b00, 1'b0);
    cycle(2'b01, 32'h0000_1010, 32'h1111_0004, 32'h1111_0005, 2'b00, 1'b0);
    idle();
    check("pre_rst_count", 128'(count_o), 128'(5));
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 128'(rd_valid_o), 128'(2'b00));
    check("rst_async_ready", 128'(wr_ready_o), 128'(1));
    check("rst_async_count", 128'(count_o), 128'(0));
    @(posedge clk); #1;
    check("rst_hold_valid", 128'(rd_valid_o), 128'(2'b00));
    check("rst_hold_count", 128'(count_o), 128'(0));
    rst = 1'b0;

    // compaction of a lone slot1
    cycle(2'b10, 32'h1c00_0008, 32'hDEAD_0000, 32'hAAAA_0001, 2'b00, 1'b0);
    check("compact_valid", 128'(rd_valid_o), 128'(2'b01));
    check("compact_pc", 128'(rd_pc_o[31:0]), 128'(32'h1c00_000c));
    check("compact_inst", 128'(rd_inst_o[31:0]), 128'(32'hAAAA_0001));
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);
    check("compact_drain", 128'(count_o), 128'(0));

    // fill to full, fifth pair dropped
    for (int i = 0; i < 4; i++)
      cycle(2'b11, 32'h100 + 32'(8 * i), 32'hC000_0000 + 32'(2 * i),
            32'hC000_0001 + 32'(2 * i), 2'b00, 1'b0);
    check("full_count", 128'(count_o), 128'(8));
    check("full_ready", 128'(wr_ready_o), 128'(0));
    cycle(2'b11, 32'h200, 32'hBAD0_0000, 32'hBAD0_0001, 2'b00, 1'b0);
    check("drop_count", 128'(count_o), 128'(8));
    check("drop_head_pc", 128'(rd_pc_o), 128'({32'h104, 32'h100}));
    check("drop_head_inst", 128'(rd_inst_o), 128'({32'hC000_0001, 32'hC000_0000}));

    // count 7: pop two with a pair write that must be dropped
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);
    check("seven_count", 128'(count_o), 128'(7));
    check("seven_ready", 128'(wr_ready_o), 128'(0));
    cycle(2'b11, 32'h300, 32'hBAD1_0000, 32'hBAD1_0001, 2'b11, 1'b0);
    check("seven_pop_count", 128'(count_o), 128'(5));

    // illegal pop pattern 10 at count 3
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
    check("three_count", 128'(count_o), 128'(3));
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0);
    check("illegal_pop_count", 128'(count_o), 128'(3));
    check("illegal_pop_head", 128'(rd_pc_o[31:0]), 128'(32'h114));

    // flush beats write and pop at count 4
    cycle(2'b01, 32'h400, 32'hD000_0000, 32'hD000_0001, 2'b00, 1'b0);
    check("four_count", 128'(count_o), 128'(4));
    cycle(2'b11, 32'h500, 32'hBAD2_0000, 32'hBAD2_0001, 2'b11, 1'b1);
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_valid", 128'(rd_valid_o), 128'(2'b00));
    check("flush_ready", 128'(wr_ready_o), 128'(1));

    // steady pop-2 / write-pair traffic across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle(2'b11, 32'h4000 + 32'(8 * i), 32'hE000_0000 + 32'(2 * i),
            32'hE000_0001 + 32'(2 * i), 2'b11, 1'b0);
      check("wrap_count", 128'(count_o), 128'(2));
      check("wrap_pc0", 128'(rd_pc_o[31:0]), 128'(32'h4000 + 32'(8 * i)));
      check("wrap_pc1", 128'(rd_pc_o[63:32]), 128'(32'h4004 + 32'(8 * i)));
    end

    // alternating single-slot writes with single pops
    for (int i = 0; i < 6; i++)
      cycle((i % 2 == 1) ? 2'b10 : 2'b01, 32'h6000 + 32'(8 * i),
            32'hF000_0000 + 32'(i), 32'hF100_0000 + 32'(i), 2'b01, 1'b0);
    check("single_count", 128'(count_o), 128'(2));
    for (int i = 0; i < 2; i++)
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
    check("final_count", 128'(count_o), 128'(0));
    check("final_valid", 128'(rd_valid_o), 128'(2'b00));
    idle();
    @(posedge clk); #1;

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
